freq_gate_capture: RTL



---
 rtl/freq_pkg.sv | 14 +
 rtl/freq_gate_capture_bcd_digit.sv | 30 +++
 rtl/freq_gate_capture.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/freq_pkg.sv
// Shared types and constants for the frequency gate/capture front end.
package freq_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int BCD_MAX    = 9;

  typedef logic [3:0] bcd_t;

  typedef enum logic {
    WARMUP,
    RUN
  } state_t;

endpackage

// File: rtl/freq_gate_capture_bcd_digit.sv
// Single BCD digit register with clear/load-one, ripple carry and saturate hold.
module bcd_digit
  import freq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic load_one,
  input  logic inc,
  input  logic sat_hold,
  output bcd_t q,
  output logic carry_out
);

  // Carry is raised whenever an increment arrives at 9, even while held,
  // so the top level can still see the over-range event.
  assign carry_out = inc & (q == bcd_t'(BCD_MAX));

  // Digit register: clear (optionally to one) wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clear) begin
      q <= load_one ? bcd_t'(1) : '0;
    end else if (inc && !sat_hold) begin
      q <= (q == bcd_t'(BCD_MAX)) ? '0 : q + 1'b1;
    end
  end

endmodule

// File: rtl/freq_gate_capture.sv
// Frequency measurement front end: synchronises eden, counts its rising edges
// in BCD over a fixed gate window and latches the result for display.
// Optional build macro FREQ_OVF_SAT_EN: live count saturates at 9999 instead
// of wrapping modulo 10000 (overflow is flagged either way).
module freq_gate_capture
  import freq_pkg::*;
#(
  parameter int GATE_CYCLES = 50000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       eden,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic       valid,
  output logic       overflow
);

  localparam int TW = $clog2(GATE_CYCLES + 1);
  localparam int WW = $clog2(SYNC_STAGES + 2);
  localparam logic [TW-1:0] TIMER_LAST = TW'(GATE_CYCLES - 1);
  localparam logic [WW-1:0] WARM_LAST  = WW'(SYNC_STAGES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise;
  state_t                 state_q, state_d;
  logic [WW-1:0]          warm_q;
  logic [TW-1:0]          timer_q;
  logic                   terminal;
  logic                   count_en;
  logic [NUM_DIGITS:0]    chain;
  logic                   sat_hold;
  logic                   sticky_q;
  bcd_t [NUM_DIGITS-1:0]  live;
  bcd_t [NUM_DIGITS-1:0]  hold_q;
  logic                   valid_q;
  logic                   overflow_q;

  // Input synchroniser followed by the edge-detect history flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], eden};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= WARMUP;
    else          state_q <= state_d;
  end

  // Next state plus terminal/count qualifiers; WARMUP ignores edges.
  always_comb begin
    state_d  = state_q;
    terminal = 1'b0;
    count_en = 1'b0;
    case (state_q)
      WARMUP: if (warm_q == WARM_LAST) state_d = RUN;
      RUN: begin
        terminal = (timer_q == TIMER_LAST);
        count_en = ~terminal;
      end
      default: state_d = WARMUP;
    endcase
  end

  // Warm-up length counter and gate timer (timer idles at 0 until RUN).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      warm_q  <= '0;
      timer_q <= '0;
    end else if (state_q == WARMUP) begin
      warm_q  <= warm_q + 1'b1;
    end else begin
      timer_q <= terminal ? '0 : timer_q + 1'b1;
    end
  end

`ifdef FREQ_OVF_SAT_EN
  assign sat_hold = (live == {NUM_DIGITS{bcd_t'(BCD_MAX)}});
`else
  assign sat_hold = 1'b0;
`endif

  // Edges on the terminal cycle reload the counter to one rather than
  // incrementing, so each edge lands in exactly one window.
  assign chain[0] = count_en & rise;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk       (clk),
      .rst_n     (reset_n),
      .clear     (terminal),
      .load_one  ((g == 0) ? rise : 1'b0),
      .inc       (chain[g]),
      .sat_hold  (sat_hold),
      .q         (live[g]),
      .carry_out (chain[g+1])
    );
  end

  // Sticky overflow for the live window: set on carry out of the top digit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                sticky_q <= 1'b0;
    else if (terminal)           sticky_q <= 1'b0;
    else if (chain[NUM_DIGITS])  sticky_q <= 1'b1;
  end

  // Hold registers and valid pulse, updated only at window end.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q     <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= terminal;
      if (terminal) begin
        hold_q     <= live;
        overflow_q <= sticky_q;
      end
    end
  end

  assign dig0     = hold_q[0];
  assign dig1     = hold_q[1];
  assign dig2     = hold_q[2];
  assign dig3     = hold_q[3];
  assign valid    = valid_q;
  assign overflow = overflow_q;

endmodule
